mbist_march_ctrl: RTL and testbench

- March C- BIST sequencer for a single-port 8-bit-wide SRAM.
- Drives SRAM address, control and write data.
- Generates the expected-data stream for the registered 8-bit comparator and accumulates its RESULT into a PASS/FAIL verdict.
- Sits between the top-level test interface (START/DONE) and the SRAM + comparator datapath.

---
 rtl/mbist_pkg.sv | 44 ++++
 rtl/mbist_addr_gen.sv | 41 ++++
 rtl/mbist_march_ctrl.sv | 238 +++++++++++++++++++++++
 tb/tb_mbist_march_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/mbist_pkg.sv
// Shared definitions for the March C- BIST controller: FSM states, element indices,
// per-element descriptors and data backgrounds.
package mbist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_FINISH = 2'd3
    } state_e;

    localparam int unsigned ELEM_W = 3;

    localparam logic [ELEM_W-1:0] M0 = 3'd0;
    localparam logic [ELEM_W-1:0] M1 = 3'd1;
    localparam logic [ELEM_W-1:0] M2 = 3'd2;
    localparam logic [ELEM_W-1:0] M3 = 3'd3;
    localparam logic [ELEM_W-1:0] M4 = 3'd4;
    localparam logic [ELEM_W-1:0] M5 = 3'd5;

    localparam logic [7:0] BG0 = 8'h00;
    localparam logic [7:0] BG1 = 8'hFF;

    typedef struct packed {
        logic       down;
        logic [7:0] rd_bg;
        logic [7:0] wr_bg;
        logic       has_rd;
        logic       has_wr;
    } elem_desc_t;

    // Indexed by element number; slots 6 and 7 are never reached and describe no access.
    localparam elem_desc_t ELEM_DESC [8] = '{
        '{down: 1'b0, rd_bg: BG0, wr_bg: BG0, has_rd: 1'b0, has_wr: 1'b1},
        '{down: 1'b0, rd_bg: BG0, wr_bg: BG1, has_rd: 1'b1, has_wr: 1'b1},
        '{down: 1'b0, rd_bg: BG1, wr_bg: BG0, has_rd: 1'b1, has_wr: 1'b1},
        '{down: 1'b1, rd_bg: BG0, wr_bg: BG1, has_rd: 1'b1, has_wr: 1'b1},
        '{down: 1'b1, rd_bg: BG1, wr_bg: BG0, has_rd: 1'b1, has_wr: 1'b1},
        '{down: 1'b0, rd_bg: BG0, wr_bg: BG0, has_rd: 1'b1, has_wr: 1'b0},
        '{down: 1'b0, rd_bg: BG0, wr_bg: BG0, has_rd: 1'b0, has_wr: 1'b0},
        '{down: 1'b0, rd_bg: BG0, wr_bg: BG0, has_rd: 1'b0, has_wr: 1'b0}
    };

endpackage

// File: rtl/mbist_addr_gen.sv
// Loadable up/down March address counter with a terminal-count flag at the end of the
// current sweep direction; it never steps past the tested range.
module mbist_addr_gen #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_val,
    input  logic              step,
    input  logic              down,
    output logic [ADDR_W-1:0] addr,
    output logic              tc_c
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    logic [ADDR_W-1:0] addr_q, addr_d;

    assign tc_c = down ? (addr_q == '0) : (addr_q == LAST);
    assign addr = addr_q;

    always_comb begin
        addr_d = addr_q;
        if (load) begin
            addr_d = load_val;
        end else if (step && !tc_c) begin
            addr_d = down ? (addr_q - ADDR_W'(1)) : (addr_q + ADDR_W'(1));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q <= '0;
        end else begin
            addr_q <= addr_d;
        end
    end

endmodule

// File: rtl/mbist_march_ctrl.sv
// March C- MBIST sequencer: drives a single-port SRAM, aligns expected data with returning reads
// and folds the registered comparator flag into a sticky verdict. MBIST_FAIL_LOG_EN adds a first-fail log.
module mbist_march_ctrl
    import mbist_pkg::*;
#(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned RD_LAT = 1
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              START,
    output logic              BUSY,
    output logic              DONE,
    output logic              PASS,
    output logic              SRAM_CE,
    output logic              SRAM_WE,
    output logic [ADDR_W-1:0] SRAM_ADDR,
    output logic [7:0]        SRAM_WDATA,
    output logic [7:0]        EXP_DATA,
    input  logic              RESULT
`ifdef MBIST_FAIL_LOG_EN
    ,
    output logic [ADDR_W-1:0] FAIL_ADDR,
    output logic [ELEM_W-1:0] FAIL_ELEM
`endif
);

    localparam int unsigned PIPE   = RD_LAT + 1;
    localparam int unsigned DCNT_W = 3;
    localparam logic [ADDR_W-1:0] TOP_ADDR = ADDR_W'(DEPTH - 1);

    state_e            state_q, state_d;
    logic [ELEM_W-1:0] elem_q, elem_d, elem_nxt;
    logic              wr_ph_q, wr_ph_d;
    logic              busy_q, busy_d, done_q, done_d, pass_q, pass_d, fail_q, fail_d;
    logic              ce_q, ce_d, we_q, we_d;
    logic [7:0]        wdata_q, wdata_d;
    logic [DCNT_W-1:0] drain_q, drain_d;
    logic [PIPE-1:0]   pv_q, pv_d;
    logic [7:0]        pexp_q [PIPE];
    logic [7:0]        pexp_d [PIPE];
    logic              rd_issue, cur_down;
    logic              ag_load, ag_step, ag_tc;
    logic [ADDR_W-1:0] ag_load_val, ag_addr;
`ifdef MBIST_FAIL_LOG_EN
    logic [ADDR_W-1:0] paddr_q [PIPE];
    logic [ADDR_W-1:0] paddr_d [PIPE];
    logic [ELEM_W-1:0] pelem_q [PIPE];
    logic [ELEM_W-1:0] pelem_d [PIPE];
    logic [ADDR_W-1:0] flog_addr_q, flog_addr_d;
    logic [ELEM_W-1:0] flog_elem_q, flog_elem_d;
`endif

    assign cur_down = ELEM_DESC[elem_q].down;
    assign elem_nxt = elem_q + ELEM_W'(1);
    assign rd_issue = ce_q & ~we_q;

    mbist_addr_gen #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_addr_gen (
        .clk      (CLK),
        .rst      (RESET),
        .load     (ag_load),
        .load_val (ag_load_val),
        .step     (ag_step),
        .down     (cur_down),
        .addr     (ag_addr),
        .tc_c     (ag_tc)
    );

    always_comb begin
        state_d     = state_q;
        elem_d      = elem_q;
        wr_ph_d     = wr_ph_q;
        busy_d      = busy_q;
        done_d      = done_q;
        pass_d      = pass_q;
        fail_d      = fail_q;
        ce_d        = 1'b0;
        we_d        = 1'b0;
        wdata_d     = wdata_q;
        drain_d     = drain_q;
        ag_load     = 1'b0;
        ag_load_val = '0;
        ag_step     = 1'b0;

        // Compare pipeline: each issued read carries its tag towards the comparator result.
        pv_d      = {pv_q[PIPE-2:0], rd_issue};
        pexp_d[0] = rd_issue ? ELEM_DESC[elem_q].rd_bg : BG0;
        for (int i = 1; i < int'(PIPE); i++) begin
            pexp_d[i] = pexp_q[i-1];
        end
`ifdef MBIST_FAIL_LOG_EN
        flog_addr_d = flog_addr_q;
        flog_elem_d = flog_elem_q;
        paddr_d[0]  = ag_addr;
        pelem_d[0]  = elem_q;
        for (int i = 1; i < int'(PIPE); i++) begin
            paddr_d[i] = paddr_q[i-1];
            pelem_d[i] = pelem_q[i-1];
        end
`endif

        if (pv_q[PIPE-1] && !RESULT) begin
            fail_d = 1'b1;
`ifdef MBIST_FAIL_LOG_EN
            if (!fail_q) begin
                flog_addr_d = paddr_q[PIPE-1];
                flog_elem_d = pelem_q[PIPE-1];
            end
`endif
        end

        case (state_q)
            ST_IDLE, ST_FINISH: begin
                if (START) begin
                    state_d     = ST_RUN;
                    elem_d      = M0;
                    wr_ph_d     = 1'b0;
                    busy_d      = 1'b1;
                    done_d      = 1'b0;
                    pass_d      = 1'b0;
                    fail_d      = 1'b0;
                    ag_load     = 1'b1;
                    ag_load_val = '0;
                    ce_d        = 1'b1;
                    we_d        = ~ELEM_DESC[M0].has_rd;
                    wdata_d     = ELEM_DESC[M0].wr_bg;
`ifdef MBIST_FAIL_LOG_EN
                    flog_addr_d = '0;
                    flog_elem_d = '0;
`endif
                end
            end
            ST_RUN: begin
                if (ELEM_DESC[elem_q].has_rd && ELEM_DESC[elem_q].has_wr && !wr_ph_q) begin
                    wr_ph_d = 1'b1;
                    ce_d    = 1'b1;
                    we_d    = 1'b1;
                    wdata_d = ELEM_DESC[elem_q].wr_bg;
                end else if (!ag_tc) begin
                    ag_step = 1'b1;
                    wr_ph_d = 1'b0;
                    ce_d    = 1'b1;
                    we_d    = ~ELEM_DESC[elem_q].has_rd;
                    if (!ELEM_DESC[elem_q].has_rd) begin
                        wdata_d = ELEM_DESC[elem_q].wr_bg;
                    end
                end else if (elem_q == M5) begin
                    state_d = ST_DRAIN;
                    drain_d = '0;
                end else begin
                    // Next element starts in the same cycle at the origin of its sweep.
                    elem_d      = elem_nxt;
                    ag_load     = 1'b1;
                    ag_load_val = ELEM_DESC[elem_nxt].down ? TOP_ADDR : '0;
                    wr_ph_d     = 1'b0;
                    ce_d        = 1'b1;
                    we_d        = ~ELEM_DESC[elem_nxt].has_rd;
                    if (!ELEM_DESC[elem_nxt].has_rd) begin
                        wdata_d = ELEM_DESC[elem_nxt].wr_bg;
                    end
                end
            end
            ST_DRAIN: begin
                if (drain_q == DCNT_W'(RD_LAT + 1)) begin
                    state_d = ST_FINISH;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = ~fail_d;
                end else begin
                    drain_d = drain_q + DCNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= ST_IDLE;
            elem_q  <= M0;
            wr_ph_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            fail_q  <= 1'b0;
            ce_q    <= 1'b0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            drain_q <= '0;
            pv_q    <= '0;
            pexp_q  <= '{default: '0};
`ifdef MBIST_FAIL_LOG_EN
            paddr_q     <= '{default: '0};
            pelem_q     <= '{default: '0};
            flog_addr_q <= '0;
            flog_elem_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            elem_q  <= elem_d;
            wr_ph_q <= wr_ph_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            fail_q  <= fail_d;
            ce_q    <= ce_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            drain_q <= drain_d;
            pv_q    <= pv_d;
            pexp_q  <= pexp_d;
`ifdef MBIST_FAIL_LOG_EN
            paddr_q     <= paddr_d;
            pelem_q     <= pelem_d;
            flog_addr_q <= flog_addr_d;
            flog_elem_q <= flog_elem_d;
`endif
        end
    end

    assign BUSY       = busy_q;
    assign DONE       = done_q;
    assign PASS       = pass_q;
    assign SRAM_CE    = ce_q;
    assign SRAM_WE    = we_q;
    assign SRAM_ADDR  = ag_addr;
    assign SRAM_WDATA = wdata_q;
    assign EXP_DATA   = pexp_q[RD_LAT-1];
`ifdef MBIST_FAIL_LOG_EN
    assign FAIL_ADDR  = flog_addr_q;
    assign FAIL_ELEM  = flog_elem_q;
`endif

endmodule

// File: tb/tb_mbist_march_ctrl.sv
// Directed bench for mbist_march_ctrl: two instances (RD_LAT=1 and RD_LAT=3) on 16-word
// behavioural SRAMs with a registered comparator and injectable faults.
module tb_mbist_march_ctrl;

    logic       clk;
    logic       reset1, start1, busy1, done1, pass1, ce1, we1, result1;
    logic [3:0] addr1;
    logic [7:0] wd1, exp1, rdp1;
    logic       reset3, start3, busy3, done3, pass3, ce3, we3, result3;
    logic [3:0] addr3;
    logic [7:0] wd3, exp3;
    logic [7:0] rdp3 [3];
    logic [7:0] mem1 [16];
    logic [7:0] mem3 [16];
    logic       fault_sa;
    logic [12:0] acc_rec [200];
    int         n_checks, n_errors;
    int         done_at, n_acc;
`ifdef MBIST_FAIL_LOG_EN
    logic [3:0] fa1, fa3;
    logic [2:0] fe1, fe3;
`endif

    mbist_march_ctrl #(.ADDR_W(4), .DEPTH(16), .RD_LAT(1)) dut1 (
        .CLK(clk), .RESET(reset1), .START(start1), .BUSY(busy1), .DONE(done1), .PASS(pass1),
        .SRAM_CE(ce1), .SRAM_WE(we1), .SRAM_ADDR(addr1), .SRAM_WDATA(wd1), .EXP_DATA(exp1),
        .RESULT(result1)
`ifdef MBIST_FAIL_LOG_EN
        , .FAIL_ADDR(fa1), .FAIL_ELEM(fe1)
`endif
    );

    mbist_march_ctrl #(.ADDR_W(4), .DEPTH(16), .RD_LAT(3)) dut3 (
        .CLK(clk), .RESET(reset3), .START(start3), .BUSY(busy3), .DONE(done3), .PASS(pass3),
        .SRAM_CE(ce3), .SRAM_WE(we3), .SRAM_ADDR(addr3), .SRAM_WDATA(wd3), .EXP_DATA(exp3),
        .RESULT(result3)
`ifdef MBIST_FAIL_LOG_EN
        , .FAIL_ADDR(fa3), .FAIL_ELEM(fe3)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM 1: one-cycle read latency, optional bit-0 stuck-at-1 at address 5.
    always @(posedge clk) begin
        if (ce1 && we1) mem1[addr1] <= wd1;
        rdp1    <= (ce1 && !we1) ? (mem1[addr1] | {7'b0, fault_sa && (addr1 == 4'd5)}) : 8'h5A;
        result1 <= (rdp1 == exp1);
    end

    // SRAM 3: three-cycle read latency, writing 0xFF to address 2 also sets address 3.
    always @(posedge clk) begin
        if (ce3 && we3) begin
            mem3[addr3] <= wd3;
            if (addr3 == 4'd2 && wd3 == 8'hFF) mem3[3] <= 8'hFF;
        end
        rdp3[0] <= (ce3 && !we3) ? mem3[addr3] : 8'h5A;
        rdp3[1] <= rdp3[0];
        rdp3[2] <= rdp3[1];
        result3 <= (rdp3[2] == exp3);
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, expv);
        end
    endtask

    // Expected {we, addr, wdata-if-write} of access n in a 16-word March C- run.
    function automatic logic [12:0] exp_acc(input int n);
        int m, k;
        logic w;
        logic [3:0] a;
        logic [7:0] d;
        if (n < 16) begin
            w = 1'b1; a = 4'(n); d = 8'h00;
        end else if (n < 144) begin
            m = (n - 16) / 32;
            k = (n - 16) % 32;
            w = k[0];
            a = (m < 2) ? 4'(k / 2) : 4'(15 - k / 2);
            d = (w && (m % 2 == 0)) ? 8'hFF : 8'h00;
        end else begin
            w = 1'b0; a = 4'(n - 144); d = 8'h00;
        end
        return {w, a, d};
    endfunction

    task automatic run1(input int restart_at, output int d_at, output int n_a);
        int edges;
        @(negedge clk);
        start1 = 1'b1;
        @(posedge clk);
        #1;
        check("busy_at_start", busy1, 1);
        check("done_cleared", done1, 0);
        edges = 0; n_a = 0; d_at = -1;
        while (d_at < 0 && edges < 400) begin
            @(negedge clk);
            start1 = (edges == restart_at);
            if (ce1) begin
                if (n_a < 200) acc_rec[n_a] = {we1, addr1, we1 ? wd1 : 8'h00};
                n_a++;
            end
            @(posedge clk);
            #1;
            edges++;
            if (done1) d_at = edges;
        end
        start1 = 1'b0;
    endtask

    task automatic run3(output int d_at);
        int edges;
        @(negedge clk);
        start3 = 1'b1;
        @(posedge clk);
        #1;
        check("busy3_at_start", busy3, 1);
        edges = 0; d_at = -1;
        while (d_at < 0 && edges < 400) begin
            @(negedge clk);
            start3 = 1'b0;
            @(posedge clk);
            #1;
            edges++;
            if (done3) d_at = edges;
        end
    endtask

    initial begin
        n_checks = 0; n_errors = 0;
        reset1 = 1'b1; reset3 = 1'b1; start1 = 1'b0; start3 = 1'b0; fault_sa = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy1, 0);
        check("rst_done", done1, 0);
        check("rst_pass", pass1, 0);
        check("rst_ce", ce1, 0);
        check("rst_exp", exp1, 0);
        check("rst_ce3", ce3, 0);
        @(negedge clk);
        reset1 = 1'b0; reset3 = 1'b0;

        // Fault-free run: 160 accesses, DONE after 163 edges, full access order.
        run1(-1, done_at, n_acc);
        check("clean_done_edge", done_at, 163);
        check("clean_n_acc", n_acc, 160);
        check("clean_pass", pass1, 1);
        check("clean_busy_off", busy1, 0);
        check("clean_ce_off", ce1, 0);
        check("clean_exp_idle", exp1, 0);
        for (int n = 0; n < 160; n++) check($sformatf("acc%0d", n), acc_rec[n], exp_acc(n));
`ifdef MBIST_FAIL_LOG_EN
        check("clean_fail_addr", fa1, 0);
        check("clean_fail_elem", fe1, 0);
`endif

        // Stuck-at-1 on bit 0 of address 5.
        fault_sa = 1'b1;
        run1(-1, done_at, n_acc);
        check("sa_done_edge", done_at, 163);
        check("sa_pass", pass1, 0);
`ifdef MBIST_FAIL_LOG_EN
        check("sa_fail_addr", fa1, 5);
        check("sa_fail_elem", fe1, 1);
`endif
        fault_sa = 1'b0;

        // Reset during M2 (cycle 59 is M2 write to address 5).
        @(negedge clk);
        start1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start1 = 1'b0;
        repeat (59) @(negedge clk);
        check("m2_ce", ce1, 1);
        check("m2_addr", addr1, 5);
        check("m2_we", we1, 1);
        reset1 = 1'b1;
        @(posedge clk);
        #1;
        check("abort_ce", ce1, 0);
        check("abort_busy", busy1, 0);
        check("abort_done", done1, 0);
        check("abort_pass", pass1, 0);
        @(negedge clk);
        reset1 = 1'b0;
        run1(-1, done_at, n_acc);
        check("post_rst_done_edge", done_at, 163);
        check("post_rst_pass", pass1, 1);
`ifdef MBIST_FAIL_LOG_EN
        check("post_rst_fail_addr", fa1, 0);
`endif

        // START re-pulsed mid-run is ignored.
        run1(40, done_at, n_acc);
        check("restart_done_edge", done_at, 163);
        check("restart_n_acc", n_acc, 160);
        check("restart_pass", pass1, 1);

        // RD_LAT=3 with coupling fault 2 -> 3.
        run3(done_at);
        check("cf_done_edge", done_at, 165);
        check("cf_pass", pass3, 0);
        check("cf_busy_off", busy3, 0);
`ifdef MBIST_FAIL_LOG_EN
        check("cf_fail_addr", fa3, 3);
        check("cf_fail_elem", fe3, 1);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
